ahb_spi_master_fifo: RTL and testbench

- Parametrised AHB-Lite slave SPI master for the TFT/peripheral path, sitting behind the AXI4-Lite to AHB bridge.
- Generalises the single-mode, single-CS, unbuffered SPI bridge:
  - configurable frame width
  - TX/RX FIFOs
  - SPI modes 0-3, MSB/LSB first
  - programmable SCLK divider
  - NUM_CS chip selects with manual-hold
  - per-frame DC bit, software TFT reset and interrupt.

---
 rtl/ahb_spi_master_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_ahb_spi_master_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_spi_master_fifo.sv
// rtl/ahb_spi_master_fifo.sv - AHB-Lite SPI master with TX/RX FIFOs, SPI modes 0-3, multi-CS and TFT controls
module ahb_spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CS     = 2,
  parameter int DIV_W      = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADY,
  output logic [1:0]        HRESP,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs,
  output logic              spi_dc,
  output logic              tft_reset,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE, S_GAP} state_t;
  state_t state;

  logic              dp_valid, dp_write, wr_en, rd_en;
  logic [2:0]        dp_addr;
  logic              en, cpol, cpha, lsb_first, cs_hold;
  logic [2:0]        cs_sel, irq_en;
  logic [DIV_W-1:0]  div, div_l, hp_cnt;
  logic              tx_ovf, rx_ovf, rx_unf, busy;
  logic [DATA_W:0]   tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wr, tx_rd, rx_wr, rx_rd, tx_cnt, rx_cnt;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push_req, tx_push, tx_pop, rx_push_req, rx_push, rx_pop_req, rx_pop;
  logic [DATA_W:0]   tx_head;
  logic [DATA_W-1:0] tx_sh, rx_sh, tx_next;
  logic [EW-1:0]     edge_cnt;
  logic              cpol_l, cpha_l, lsb_l, hp_end, sample;
  logic [2:0]        cs_sel_l;
  logic              unused;

  assign HREADY = 1'b1;
  assign HRESP  = 2'b00;
  assign unused = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};
  assign wr_en  = dp_valid & dp_write;
  assign rd_en  = dp_valid & ~dp_write;
  assign busy   = (state != S_IDLE);

  assign tx_cnt   = tx_wr - tx_rd;
  assign rx_cnt   = rx_wr - rx_rd;
  assign tx_full  = tx_cnt[AW];
  assign rx_full  = rx_cnt[AW];
  assign tx_empty = (tx_cnt == '0);
  assign rx_empty = (rx_cnt == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign tx_push_req = wr_en && (dp_addr == 3'd2);
  assign tx_pop      = (state == S_LOAD);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_pop_req  = rd_en && (dp_addr == 3'd3);
  assign rx_pop      = rx_pop_req && !rx_empty;
  assign rx_push_req = (state == S_DONE);
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  assign tx_head = tx_mem[tx_rd[AW-1:0]];
  assign hp_end  = (hp_cnt == div_l);
  assign sample  = ~edge_cnt[0] ^ cpha_l;
  assign tx_next = lsb_l ? (tx_sh >> 1) : (tx_sh << 1);

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [2:0] sel);
    logic [NUM_CS-1:0] c;
    c = '1;
    for (int i = 0; i < NUM_CS; i++) if (sel == 3'(i)) c[i] = 1'b0;
    return c;
  endfunction

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else begin
      dp_valid <= HSEL & HTRANS[1] & HREADY;
      dp_write <= HWRITE;
      dp_addr  <= HADDR[4:2];
    end
  end

  always_ff @(posedge HCLK) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= {HWDATA[31], HWDATA[DATA_W-1:0]};
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_wr <= '0; tx_rd <= '0; rx_wr <= '0; rx_rd <= '0;
      en <= 1'b0; cpol <= 1'b0; cpha <= 1'b0; lsb_first <= 1'b0;
      tft_reset <= 1'b0; cs_sel <= '0; cs_hold <= 1'b0;
      div <= DIV_W'(4);
      tx_ovf <= 1'b0; rx_ovf <= 1'b0; rx_unf <= 1'b0;
      irq_en <= '0; irq <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (wr_en) begin
        case (dp_addr)
          3'd0: begin
            en <= HWDATA[0]; cpol <= HWDATA[1]; cpha <= HWDATA[2];
            lsb_first <= HWDATA[3]; tft_reset <= HWDATA[4];
            cs_sel <= HWDATA[10:8]; cs_hold <= HWDATA[15];
          end
          3'd1: div <= HWDATA[DIV_W-1:0];
          3'd4: begin
            if (HWDATA[5]) tx_ovf <= 1'b0;
            if (HWDATA[6]) rx_ovf <= 1'b0;
            if (HWDATA[7]) rx_unf <= 1'b0;
          end
          3'd5: irq_en <= HWDATA[2:0];
          default: ;
        endcase
      end
      if (tx_push_req && !tx_push) tx_ovf <= 1'b1;
      if (rx_push_req && !rx_push) rx_ovf <= 1'b1;
      if (rx_pop_req && rx_empty)  rx_unf <= 1'b1;
      irq <= |(irq_en & {tx_ovf | rx_ovf | rx_unf, !rx_empty, tx_empty && !busy});
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (dp_addr)
        3'd0: HRDATA = {16'b0, cs_hold, 4'b0, cs_sel, 3'b0, tft_reset, lsb_first, cpha, cpol, en};
        3'd1: HRDATA[DIV_W-1:0] = div;
        3'd3: if (!rx_empty) HRDATA[DATA_W-1:0] = rx_mem[rx_rd[AW-1:0]];
        3'd4: HRDATA[7:0] = {rx_unf, rx_ovf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full, busy};
        3'd5: HRDATA[2:0] = irq_en;
        default: ;
      endcase
    end
  end

  // Engine: even edge_cnt is the leading SCLK edge; with CPHA=1 the first leading edge only exposes bit 0
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      spi_sclk <= 1'b0; spi_mosi <= 1'b0; spi_cs <= '1; spi_dc <= 1'b0;
      cpol_l <= 1'b0; cpha_l <= 1'b0; lsb_l <= 1'b0; cs_sel_l <= '0;
      div_l <= '0; hp_cnt <= '0; edge_cnt <= '0; tx_sh <= '0; rx_sh <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          spi_sclk <= cpol;
          if (!cs_hold) spi_cs <= '1;
          if (en && !tx_empty) state <= S_LOAD;
        end
        S_LOAD: begin
          cpol_l <= cpol; cpha_l <= cpha; lsb_l <= lsb_first;
          div_l <= div; cs_sel_l <= cs_sel;
          tx_sh <= tx_head[DATA_W-1:0];
          rx_sh <= '0;
          spi_dc <= tx_head[DATA_W];
          spi_mosi <= first_bit(tx_head[DATA_W-1:0], lsb_first);
          spi_cs <= cs_decode(cs_sel);
          spi_sclk <= cpol;
          hp_cnt <= '0;
          edge_cnt <= '0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (hp_end) begin
            hp_cnt <= '0;
            spi_sclk <= ~spi_sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (sample)
              rx_sh <= lsb_l ? {spi_miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], spi_miso};
            else if (!cpha_l || edge_cnt != '0) begin
              tx_sh <= tx_next;
              spi_mosi <= first_bit(tx_next, lsb_l);
            end
            if (edge_cnt == LAST_EDGE) state <= S_DONE;
          end else begin
            hp_cnt <= hp_cnt + 1'b1;
          end
        end
        S_DONE: begin
          hp_cnt <= '0;
          if (cs_hold && cs_sel == cs_sel_l) begin
            state <= (en && !tx_empty) ? S_LOAD : S_IDLE;
          end else begin
            spi_cs <= '1;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (hp_end) state <= S_IDLE;
          else hp_cnt <= hp_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_spi_master_fifo.sv
// tb/tb_ahb_spi_master_fifo.sv - scoreboard bench: AHB read data and SPI MOSI frames checked by monitors
module tb_ahb_spi_master_fifo;
  logic        HCLK, HRESETn, HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HREADY, spi_sclk, spi_mosi, spi_miso, spi_dc, tft_reset, irq;
  logic [1:0]  spi_cs;

  ahb_spi_master_fifo dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs),
    .spi_dc(spi_dc), .tft_reset(tft_reset), .irq(irq)
  );

  assign spi_miso = spi_mosi;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct { string name; logic [31:0] data; } rd_t;
  typedef struct { logic [7:0] data; logic dc; logic [1:0] cs; } frm_t;
  rd_t  rd_q[$];
  frm_t frame_q[$];

  int total = 0;
  int bad = 0;
  logic mon_lsb = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endfunction

  logic dp_rd;
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) dp_rd <= 1'b0;
    else dp_rd <= HSEL && HTRANS[1] && !HWRITE;

  always @(negedge HCLK) begin
    if (dp_rd) begin
      if (rd_q.size() == 0) chk("unexpected_read", HRDATA, 32'hDEAD_BEEF);
      else begin
        rd_t e;
        e = rd_q.pop_front();
        chk(e.name, HRDATA, e.data);
      end
    end
  end

  int bitn = 0, frames_seen = 0, cs0_rise = 0, cs0_fall = 0;
  logic [7:0] shreg = '0;
  logic prev_sclk = 1'b0, prev_cs0 = 1'b1;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      bitn = 0;
    end else begin
      if (spi_cs[0] && !prev_cs0) cs0_rise++;
      if (!spi_cs[0] && prev_cs0) cs0_fall++;
      if (spi_sclk && !prev_sclk && spi_cs != 2'b11) begin
        shreg = mon_lsb ? {spi_mosi, shreg[7:1]} : {shreg[6:0], spi_mosi};
        bitn++;
        if (bitn == 8) begin
          bitn = 0;
          frames_seen++;
          if (frame_q.size() == 0) chk("unexpected_frame", {24'b0, shreg}, 32'hFFFF_FFFF);
          else begin
            frm_t f;
            f = frame_q.pop_front();
            chk("frame_mosi", {24'b0, shreg}, {24'b0, f.data});
            chk("frame_dc", {31'b0, spi_dc}, {31'b0, f.dc});
            chk("frame_cs", {30'b0, spi_cs}, {30'b0, f.cs});
          end
        end
      end
    end
    prev_sclk = spi_sclk;
    prev_cs0  = spi_cs[0];
  end

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    rd_t e;
    e.name = name; e.data = exp;
    rd_q.push_back(e);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic send(input logic [31:0] w, input logic [1:0] cs);
    frm_t f;
    f.data = w[7:0]; f.dc = w[31]; f.cs = cs;
    frame_q.push_back(f);
    ahb_write(32'h08, w);
  endtask

  task automatic wait_frames(input int budget);
    int n = 0;
    while (frame_q.size() != 0 && n < budget) begin
      @(posedge HCLK);
      n++;
    end
    if (frame_q.size() != 0) begin
      chk("frame_timeout", frame_q.size(), 0);
      frame_q.delete();
    end
    repeat (12) @(posedge HCLK);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  initial begin
    int base, n;
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
    settle(3);
    chk("rst_cs", {30'b0, spi_cs}, 32'h3);
    chk("rst_sclk", {31'b0, spi_sclk}, 0);
    chk("rst_tft", {31'b0, tft_reset}, 0);
    chk("rst_hrdata", HRDATA, 0);
    HRESETn = 1'b1;
    chk("hready_hresp", {29'b0, HREADY, HRESP}, 32'h4);
    ahb_read(32'h10, 32'h14, "rst_status");
    ahb_read(32'h04, 32'h4, "rst_div");
    ahb_read(32'h18, 32'h0, "unmapped_read");
    ahb_write(32'h00, 32'h11);
    settle(2);
    chk("tft_reset_set", {31'b0, tft_reset}, 1);

    // mode 0, DIV=1, CS0, DC=1
    ahb_write(32'h04, 32'h1);
    mon_lsb = 1'b0;
    send(32'h8000_00A5, 2'b10);
    wait_frames(400);
    chk("dc_after_frame", {31'b0, spi_dc}, 1);
    ahb_read(32'h0C, 32'hA5, "rx_a5");
    ahb_read(32'h10, 32'h14, "status_idle");

    // mode 3, LSB first, CS1
    mon_lsb = 1'b1;
    base = cs0_fall;
    ahb_write(32'h00, 32'h11F);
    settle(3);
    chk("sclk_idle_high", {31'b0, spi_sclk}, 1);
    send(32'h3C, 2'b01);
    wait_frames(400);
    chk("sclk_idle_high_after", {31'b0, spi_sclk}, 1);
    chk("cs0_untouched", cs0_fall - base, 0);
    ahb_read(32'h0C, 32'h3C, "rx_3c");

    // overflow with EN=0, then exactly FIFO_DEPTH frames
    mon_lsb = 1'b0;
    ahb_write(32'h00, 32'h10);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        frm_t f;
        f.data = 8'(8'h10 + i); f.dc = 1'b0; f.cs = 2'b10;
        frame_q.push_back(f);
      end
      ahb_write(32'h08, 32'h10 + i);
    end
    ahb_read(32'h10, 32'h32, "status_tx_full_ovf");
    base = frames_seen;
    ahb_write(32'h00, 32'h11);
    wait_frames(3000);
    settle(40);
    chk("frames_sent", frames_seen - base, 8);
    ahb_read(32'h10, 32'h2C, "status_rx_full");
    ahb_write(32'h10, 32'h20);
    ahb_read(32'h10, 32'h0C, "status_ovf_cleared");
    for (int i = 0; i < 8; i++) ahb_read(32'h0C, 32'h10 + i, "rx_drain");
    ahb_read(32'h10, 32'h14, "status_drained");

    // CS_HOLD across three frames
    ahb_write(32'h00, 32'h8011);
    base = cs0_rise;
    send(32'h81, 2'b10);
    send(32'h42, 2'b10);
    send(32'h24, 2'b10);
    wait_frames(1500);
    chk("hold_no_gap", cs0_rise - base, 0);
    chk("hold_cs_low_idle", {30'b0, spi_cs}, 32'h2);
    ahb_write(32'h00, 32'h11);
    settle(4);
    chk("hold_released", {30'b0, spi_cs}, 32'h3);
    chk("hold_release_rise", cs0_rise - base, 1);
    ahb_read(32'h0C, 32'h81, "rx_hold0");
    ahb_read(32'h0C, 32'h42, "rx_hold1");
    ahb_read(32'h0C, 32'h24, "rx_hold2");

    // underflow and interrupt sources
    ahb_read(32'h0C, 32'h0, "rx_empty_read");
    ahb_read(32'h10, 32'h94, "status_rx_unf");
    ahb_write(32'h14, 32'h4);
    settle(3);
    chk("irq_err", {31'b0, irq}, 1);
    ahb_write(32'h10, 32'h80);
    settle(3);
    chk("irq_err_cleared", {31'b0, irq}, 0);
    ahb_write(32'h14, 32'h1);
    settle(3);
    chk("irq_tx_done", {31'b0, irq}, 1);
    ahb_write(32'h14, 32'h2);
    settle(3);
    chk("irq_rx_avail_none", {31'b0, irq}, 0);

    // async reset mid-frame
    ahb_write(32'h08, 32'h8000_00FF);
    ahb_write(32'h08, 32'h11);
    ahb_write(32'h08, 32'h22);
    n = 0;
    while (spi_cs[0] && n < 100) begin
      @(posedge HCLK);
      n++;
    end
    repeat (6) @(posedge HCLK);
    #2;
    chk("midframe_cs_low", {31'b0, spi_cs[0]}, 0);
    chk("midframe_dc", {31'b0, spi_dc}, 1);
    HRESETn = 1'b0;
    #1;
    chk("areset_outs", {25'b0, spi_cs, spi_sclk, spi_mosi, spi_dc, tft_reset, irq}, 32'h60);
    settle(2);
    HRESETn = 1'b1;
    ahb_read(32'h10, 32'h14, "status_after_reset");
    ahb_read(32'h00, 32'h0, "ctrl_after_reset");
    ahb_read(32'h04, 32'h4, "div_after_reset");
    settle(4);
    chk("reads_all_seen", rd_q.size(), 0);
    chk("no_stray_frames", frame_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
